// File: rtl/axi_rr_arbiter.sv
// AXI read/write channel arbiter: independent read and write grant FSMs with slave address decode.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise the highest master index wins.
module axi_rr_arbiter #(
   parameter int NUM_M  = 2,
   parameter int NUM_S  = 2,
   parameter int ADDR_W = 32,
   parameter int SEL_LO = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [NUM_M-1:0]        ARVALID,
   input  logic [NUM_M-1:0]        ARREADY,
   input  logic [NUM_M-1:0]        RVALID,
   input  logic [NUM_M-1:0]        RREADY,
   input  logic [NUM_M-1:0]        RLAST,
   input  logic [NUM_M*ADDR_W-1:0] ARADDR,
   input  logic [NUM_M-1:0]        AWVALID,
   input  logic [NUM_M-1:0]        AWREADY,
   input  logic [NUM_M-1:0]        WVALID,
   input  logic [NUM_M-1:0]        WREADY,
   input  logic [NUM_M-1:0]        WLAST,
   input  logic [NUM_M-1:0]        BVALID,
   input  logic [NUM_M-1:0]        BREADY,
   input  logic [NUM_M*ADDR_W-1:0] AWADDR,
   output logic [NUM_M-1:0]        rd_grant,
   output logic [NUM_M-1:0]        wr_grant,
   output logic [NUM_S:0]          rd_sel,
   output logic [NUM_S:0]          wr_sel,
   output logic                    rd_busy,
   output logic                    wr_busy
);
   localparam int IDX_W = $clog2(NUM_M);
   localparam int SEL_W = ADDR_W - SEL_LO;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

   rd_state_t        r_rd_state;
   wr_state_t        r_wr_state;
   logic [IDX_W-1:0] r_rd_idx;
   logic [IDX_W-1:0] r_wr_idx;
   logic [NUM_M-1:0] r_rd_grant;
   logic [NUM_M-1:0] r_wr_grant;
   logic [NUM_S:0]   r_rd_sel;
   logic [NUM_S:0]   r_wr_sel;
   logic             r_wlast_seen;

   logic [IDX_W-1:0]  w_rd_win;
   logic [IDX_W-1:0]  w_wr_win;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_wr_addr;
   logic              w_unused_lo;
   logic              w_ar_hs;
   logic              w_r_last_hs;
   logic              w_aw_hs;
   logic              w_w_last_hs;
   logic              w_b_hs;

   // Out-of-range select values fall through to the default slave.
   function automatic logic [NUM_S:0] decode(input logic [SEL_W-1:0] field);
      logic [NUM_S:0] sel;
      sel        = '0;
      sel[NUM_S] = 1'b1;
      for (int s = 0; s < NUM_S; s++) begin
         if (field == SEL_W'(s)) begin
            sel    = '0;
            sel[s] = 1'b1;
         end
      end
      return sel;
   endfunction

`ifdef AXI_ARB_RR_EN
   logic [IDX_W-1:0] r_rd_ptr;
   logic [IDX_W-1:0] r_wr_ptr;

   // Scan downwards so the requester closest to the pointer is written last and wins.
   function automatic logic [IDX_W-1:0] pick(input logic [NUM_M-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] g;
      logic [IDX_W-1:0] idx;
      g = '0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_M);
         if (req[idx]) g = idx;
      end
      return g;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
      return (int'(g) == NUM_M - 1) ? '0 : IDX_W'(int'(g) + 1);
   endfunction

   assign w_rd_win = pick(ARVALID, r_rd_ptr);
   assign w_wr_win = pick(AWVALID, r_wr_ptr);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (r_rd_state == R_IDLE && |ARVALID) r_rd_ptr <= next_ptr(w_rd_win);
         if (r_wr_state == W_IDLE && |AWVALID) r_wr_ptr <= next_ptr(w_wr_win);
      end
   end
`else
   function automatic logic [IDX_W-1:0] pick(input logic [NUM_M-1:0] req);
      logic [IDX_W-1:0] g;
      g = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (req[i]) g = IDX_W'(i);
      end
      return g;
   endfunction

   assign w_rd_win = pick(ARVALID);
   assign w_wr_win = pick(AWVALID);
`endif

   always_comb begin
      w_rd_addr = '0;
      w_wr_addr = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (w_rd_win == IDX_W'(i)) w_rd_addr = ARADDR[i*ADDR_W +: ADDR_W];
         if (w_wr_win == IDX_W'(i)) w_wr_addr = AWADDR[i*ADDR_W +: ADDR_W];
      end
   end

   assign w_unused_lo = ^{w_rd_addr[SEL_LO-1:0], w_wr_addr[SEL_LO-1:0]};

   assign w_ar_hs     = ARVALID[r_rd_idx] & ARREADY[r_rd_idx];
   assign w_r_last_hs = RVALID[r_rd_idx] & RREADY[r_rd_idx] & RLAST[r_rd_idx];
   assign w_aw_hs     = AWVALID[r_wr_idx] & AWREADY[r_wr_idx];
   assign w_w_last_hs = WVALID[r_wr_idx] & WREADY[r_wr_idx] & WLAST[r_wr_idx];
   assign w_b_hs      = BVALID[r_wr_idx] & BREADY[r_wr_idx];

   // NOTE: non-blocking assignments so every register in the block samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_rd_state <= R_IDLE;
         r_rd_idx   <= '0;
         r_rd_grant <= '0;
         r_rd_sel   <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: if (|ARVALID) begin
               r_rd_idx   <= w_rd_win;
               r_rd_grant <= {{(NUM_M-1){1'b0}}, 1'b1} << w_rd_win;
               r_rd_sel   <= decode(w_rd_addr[ADDR_W-1:SEL_LO]);
               r_rd_state <= R_ADDR;
            end
            R_ADDR: if (w_ar_hs) r_rd_state <= R_DATA;
            R_DATA: if (w_r_last_hs) begin
               r_rd_grant <= '0;
               r_rd_sel   <= '0;
               r_rd_state <= R_IDLE;
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_wr_state   <= W_IDLE;
         r_wr_idx     <= '0;
         r_wr_grant   <= '0;
         r_wr_sel     <= '0;
         r_wlast_seen <= 1'b0;
      end else begin
         case (r_wr_state)
            W_IDLE: if (|AWVALID) begin
               r_wr_idx   <= w_wr_win;
               r_wr_grant <= {{(NUM_M-1){1'b0}}, 1'b1} << w_wr_win;
               r_wr_sel   <= decode(w_wr_addr[ADDR_W-1:SEL_LO]);
               r_wr_state <= W_ADDR;
            end
            // A last W beat may precede the AW handshake; remember it and skip W_DATA.
            W_ADDR: begin
               if (w_w_last_hs) r_wlast_seen <= 1'b1;
               if (w_aw_hs) r_wr_state <= (r_wlast_seen || w_w_last_hs) ? W_RESP : W_DATA;
            end
            W_DATA: if (w_w_last_hs) r_wr_state <= W_RESP;
            W_RESP: if (w_b_hs) begin
               r_wr_grant   <= '0;
               r_wr_sel     <= '0;
               r_wlast_seen <= 1'b0;
               r_wr_state   <= W_IDLE;
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   assign rd_grant = r_rd_grant;
   assign rd_sel   = r_rd_sel;
   assign rd_busy  = (r_rd_state != R_IDLE);
   assign wr_grant = r_wr_grant;
   assign wr_sel   = r_wr_sel;
   assign wr_busy  = (r_wr_state != W_IDLE);

endmodule
